// File: rtl/lc3_io_controller.sv
// LC-3 keyboard/display device registers (KBSR/KBDR/DSR/DDR) with a keystroke
// FIFO, a one-character display handshake and a prioritised interrupt request.
module lc3_io_controller #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] KBD_PRIO   = 3'd4,
  parameter logic [7:0] KBD_VEC    = 8'h80,
  parameter logic [2:0] DSP_PRIO   = 3'd3,
  parameter logic [7:0] DSP_VEC    = 8'h81
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldKBSR,
  input  logic [15:0] KBSRo,
  input  logic        rdKBDR,
  input  logic        ldDDR,
  input  logic [15:0] DDR,
  input  logic        ldDSR,
  input  logic [15:0] DSRo,
  output logic [15:0] KBDR,
  output logic [15:0] KBSRi,
  output logic [15:0] DSRi,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        key_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        IRQ,
  output logic [2:0]  INTP,
  output logic [7:0]  INTV
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] LAST_C  = (AW + 1)'(FIFO_DEPTH - 1);

  typedef enum logic {DSP_IDLE, DSP_BUSY} dsp_state_t;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] rd_ptr_reg, wr_ptr_reg, count_reg;
  logic        kb_ie_reg;
  logic        fifo_empty, fifo_full, push, pop;

  dsp_state_t  dsp_state_reg, dsp_state_next;
  logic [7:0]  disp_data_reg, disp_data_next;
  logic        overrun_reg, overrun_next;
  logic        dsp_ie_reg;
  logic        dsp_ready;

  logic        irq_reg;
  logic [2:0]  intp_reg;
  logic [7:0]  intv_reg;
  logic        kreq, dreq;

  logic        unused_bits;
  assign unused_bits = ^{KBSRo[15], KBSRo[13:0], DDR[15:8], DSRo[15], DSRo[13:1]};

  // Keyboard FIFO
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign key_ready  = !fifo_full;
  assign push       = key_valid && !fifo_full;
  assign pop        = rdKBDR && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= key_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      kb_ie_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (ldKBSR) begin
        kb_ie_reg <= KBSRo[14];
      end
    end
  end

  assign KBDR  = fifo_empty ? 16'h0000 : {8'h00, fifo_mem[rd_ptr_reg[AW-1:0]]};
  assign KBSRi = {!fifo_empty, kb_ie_reg, 14'b0};

  // Display state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      dsp_state_reg <= DSP_IDLE;
      disp_data_reg <= 8'h00;
      overrun_reg   <= 1'b0;
      dsp_ie_reg    <= 1'b0;
    end else begin
      dsp_state_reg <= dsp_state_next;
      disp_data_reg <= disp_data_next;
      overrun_reg   <= overrun_next;
      if (ldDSR) begin
        dsp_ie_reg <= DSRo[14];
      end
    end
  end

  always_comb begin
    dsp_state_next = dsp_state_reg;
    disp_data_next = disp_data_reg;
    overrun_next   = overrun_reg;
    if (ldDSR && !DSRo[0]) begin
      overrun_next = 1'b0;
    end
    // A dropped write sets overrun even if software clears it in the same cycle.
    case (dsp_state_reg)
      DSP_IDLE: begin
        if (ldDDR) begin
          dsp_state_next = DSP_BUSY;
          disp_data_next = DDR[7:0];
        end
      end
      DSP_BUSY: begin
        if (disp_ready) begin
          dsp_state_next = DSP_IDLE;
        end
        if (ldDDR) begin
          overrun_next = 1'b1;
        end
      end
      default: dsp_state_next = DSP_IDLE;
    endcase
  end

  assign dsp_ready  = (dsp_state_reg == DSP_IDLE);
  assign disp_valid = (dsp_state_reg == DSP_BUSY);
  assign disp_data  = disp_data_reg;
  assign DSRi       = {dsp_ready, dsp_ie_reg, 13'b0, overrun_reg};

  // Interrupt request, keyboard has priority
  assign kreq = !fifo_empty && kb_ie_reg;
  assign dreq = dsp_ready && dsp_ie_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_reg  <= 1'b0;
      intp_reg <= 3'd0;
      intv_reg <= 8'h00;
    end else if (kreq) begin
      irq_reg  <= 1'b1;
      intp_reg <= KBD_PRIO;
      intv_reg <= KBD_VEC;
    end else if (dreq) begin
      irq_reg  <= 1'b1;
      intp_reg <= DSP_PRIO;
      intv_reg <= DSP_VEC;
    end else begin
      irq_reg  <= 1'b0;
      intp_reg <= 3'd0;
      intv_reg <= 8'h00;
    end
  end

  assign IRQ  = irq_reg;
  assign INTP = intp_reg;
  assign INTV = intv_reg;

endmodule

// File: doc/lc3_io_controller.md
# lc3_io_controller

Memory-mapped keyboard/display responder for the LC-3 core. It owns the KBSR/KBDR/DSR/DDR device registers that the datapath addresses at xFE00–xFE06. It buffers incoming keystrokes in a 4-entry FIFO and drives a single-character display output handshake. It also raises the IRQ/INTP/INTV interrupt request consumed by the datapath.

## Interface
- FIFO_DEPTH, 4: keystroke buffer depth; power of two, minimum 2.
- KBD_PRIO, 3'd4: keyboard interrupt priority.
- KBD_VEC, 8'h80: keyboard interrupt vector.
- DSP_PRIO, 3'd3: display interrupt priority.
- DSP_VEC, 8'h81: display interrupt vector.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ldKBSR  in  1  write strobe for KBSR; data on KBSRo.
- KBSRo  in  16  KBSR write data; only bit 14 (IE) is used.
- rdKBDR  in  1  KBDR read strobe from address decode (MAR==xFE02, read); pops the FIFO.
- ldDDR  in  1  write strobe for DDR.
- DDR  in  16  character to display; only bits 7:0 are used.
- ldDSR  in  1  write strobe for DSR; data on DSRo.
- DSRo  in  16  DSR write data; bit 14 = IE; bit 0 written 0 clears overrun.
- KBDR  out  16  {8'h00, FIFO head}; 16'h0000 when empty.
- KBSRi  out  16  {!empty, kbIE, 14'b0}.
- DSRi  out  16  {dspReady, dspIE, 13'b0, overrun}.
- key_valid  in  1  keystroke source has a byte.
- key_data  in  8  keystroke byte.
- key_ready  out  1  = !full; the byte transfers when key_valid && key_ready.
- disp_valid  out  1  display byte pending.
- disp_data  out  8  display byte; stable while disp_valid is high.
- disp_ready  in  1  display sink accepts the byte.
- IRQ  out  1  interrupt request, registered.
- INTP  out  3  request priority; 0 when IRQ=0.
- INTV  out  8  request vector; 0 when IRQ=0.

## Operation
- **Keyboard FIFO**
  - Read pointer, write pointer and count, each `log2(FIFO_DEPTH)+1` bits wide; pointers wrap modulo FIFO_DEPTH.
  - Push occurs when key_valid && key_ready. Pop occurs when rdKBDR && !empty.
  - rdKBDR while empty is ignored.
  - Simultaneous push and pop: both take effect; count is unchanged.
  - When full, key_ready=0 and the source must hold its byte.
- **KBSR write:** ldKBSR loads kbIE ← KBSRo[14]. Bit 15 is read-only; writes to other bits are ignored.
- **Display state machine:** states IDLE (dspReady=1) and BUSY (dspReady=0, disp_valid=1).
  - IDLE → BUSY on ldDDR; disp_data ← DDR[7:0].
  - BUSY → IDLE on disp_valid && disp_ready.
  - ldDDR while BUSY: the write is dropped, disp_data is unchanged, and overrun is set (sticky).
  - ldDDR in the same cycle as the BUSY→IDLE handshake is also dropped and sets overrun.
- **DSR write:** ldDSR loads dspIE ← DSRo[14]. If DSRo[0]=0, overrun is cleared. DSRo[0]=1 does not set overrun. Bit 15 is read-only.
- **Interrupt**
  - kreq = KBSRi[15] && kbIE; dreq = dspReady && dspIE.
  - Next-cycle outputs: if kreq, IRQ=1, INTP=KBD_PRIO, INTV=KBD_VEC (keyboard wins ties). Else if dreq, IRQ=1, INTP=DSP_PRIO, INTV=DSP_VEC. Else all outputs are 0.
  - Requests are level-sensitive. They remain asserted until the cause clears (FIFO drained, display busy) or IE is cleared.
- **Reset** (synchronous, active-high):
  - FIFO emptied; kbIE=0, dspIE=0, overrun=0; display state = IDLE.
  - Resulting outputs: KBDR=0, KBSRi=0, DSRi=16'h8000, key_ready=1, disp_valid=0, disp_data=0, IRQ=0, INTP=0, INTV=0.
  - Reset during BUSY abandons the byte; disp_valid drops in the cycle after the reset edge.

## Timing
- KBDR, KBSRi and DSRi are combinational from registers. They reflect a push, pop or write one cycle after the strobe edge.
- Keystroke latency: accepted at edge N → KBSRi[15]=1 and KBDR valid during cycle N+1 → IRQ asserts at edge N+1 (if kbIE=1).
- ldDDR at edge N → disp_valid=1 in cycle N+1. Handshake at edge M → DSRi[15]=1 in cycle M+1 → IRQ at edge M+1 (if dspIE=1).
- The datapath samples KBDR in the same cycle rdKBDR is high; the pop takes effect at that cycle's edge.
- Handshake rules: disp_valid never deasserts before disp_ready is seen (except on reset). key_ready depends only on the registered count.

## Test plan
- Reset check: assert rst for 2 cycles → KBSRi=x0000, DSRi=x8000, KBDR=x0000, key_ready=1, disp_valid=0, IRQ=0.
- Keyboard read: push x41, then x42 → KBDR=x0041 and KBSRi=x8000. Pulse rdKBDR → KBDR=x0042. Pulse rdKBDR → KBSRi=x0000, KBDR=x0000. A third rdKBDR leaves state unchanged.
- FIFO full and wrap: push x31–x34 → key_ready=0; hold key_valid with x35 → no accept. Pop once → x35 accepted next edge. Drain → read order x32, x33, x34, x35.
- Display handshake: ldDDR with DDR=x0048 → disp_valid=1 and disp_data=x48 next cycle. Hold disp_ready=0 for 3 cycles → data stable and DSRi[15]=0. Assert disp_ready → DSRi=x8000 next cycle. ldDDR while BUSY → DSRi[0]=1. ldDSR with DSRo=x0000 clears it.
- Interrupt priority: set kbIE and dspIE, display idle, push x61 → IRQ=1, INTP=4, INTV=x80. Pop → IRQ=1, INTP=3, INTV=x81. ldDSR with DSRo=x0000 → IRQ=0.
- Reset mid-operation: display BUSY with 2 keys queued; assert rst → next cycle disp_valid=0, KBSRi=x0000, DSRi=x8000, IRQ=0.
